muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit in the EX stage, beside the ALU, fed by the same forwarded operand pair (`in1`, `in2`). It runs MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers. MTHI/MTLO write those registers directly. It raises `busy` so the hazard unit stalls any MFHI/MFLO/MTHI/MTLO or new mul/div issued while an operation is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in1  in  32  rs operand after forwarding: dividend, multiplicand, or MTHI/MTLO source.
- in2  in  32  rt operand after forwarding: divisor or multiplier.
- op  in  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- start  in  1  one-cycle request qualifying `op`; sampled only in IDLE.
- flush  in  1  pipeline flush; aborts an in-flight operation.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  registered; high while state ≠ IDLE.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start` with MULT/MULTU/DIV/DIVU:
    - Latch |in1| and |in2| for signed ops, raw values for unsigned ops.
    - Latch the result-sign flags.
    - Clear the 6-bit iteration counter.
    - Go to CALC.
  - `start` with MTHI: hi ← in1; stay in IDLE.
  - `start` with MTLO: lo ← in1; stay in IDLE.
  - `start` with op 000/111: no effect.
- **CALC**: one radix-2 step per cycle, 32 steps total.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step on a 32-bit partial remainder plus a 32-bit quotient shift register.
  - Go to FIX when counter = 31.
- **FIX**: apply signs, write hi/lo, return to IDLE.
  - MULT: 64-bit product negated if in1[31]^in2[31]; hi = product[63:32], lo = product[31:0].
  - MULTU: raw 64-bit product.
  - DIV: lo = quotient, negated if signs differ; hi = remainder, carrying the sign of the dividend.
  - DIVU: lo = quotient, hi = remainder, no sign fix.
  - Divide by zero, signed or unsigned: lo = 0xFFFFFFFF, hi = original in1 (raw).
  - Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- **Ignored inputs**
  - `start` while in CALC or FIX, including MTHI/MTLO, has no effect. The hazard unit guarantees this is never relied upon.
- **flush**
  - In CALC: next state IDLE; hi/lo keep their pre-operation values.
  - In FIX: the FIX write completes, because the instruction has already committed past EX.
  - In IDLE, `flush` has priority over `start` in the same cycle: start is dropped.
- **reset**: overrides everything, including mid-operation. State ← IDLE, hi ← 0, lo ← 0, busy ← 0, counter ← 0.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1–32: CALC, busy = 1.
- Cycle 33: FIX, busy = 1.
- The hi/lo update is visible from cycle 34; busy = 0 in cycle 34.
- Total mul/div latency is 34 cycles from start to readable result, with busy high for 33 cycles.
- MTHI/MTLO: value visible on hi/lo the cycle after `start`; busy stays 0.
- Back-to-back operations: a new `start` is accepted in cycle 34, the first IDLE cycle.
- Operands are consumed only at the start edge. `in1`/`in2` may change freely afterwards.
- hi/lo are stable at all times except the single edge ending FIX, or an MT write.

## Test plan
- MULT in1=0xFFFFFFFD (−3), in2=5 -> busy high 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; back-to-back MULTU 2×3 accepted in the first IDLE cycle -> hi=0, lo=6.
- DIV in1=0xFFFFFFF9 (−7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU in1=7, in2=0 -> lo=0xFFFFFFFF, hi=7. Then MTLO in1=0x1234 -> lo=0x1234 the next cycle, busy never asserted.
- MULT 4×4 started, MTHI 0xAAAA asserted at cycle 10, flush asserted at cycle 20 -> MTHI ignored; IDLE at cycle 21; hi/lo unchanged from before the MULT.
- DIVU 100/7 with reset asserted at cycle 15 -> cycle 16: busy=0, hi=0, lo=0; a fresh DIVU 100/7 then gives lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_if.sv
// Operand/request bundle between the EX stage and the multiply/divide unit,
// plus the architectural HI/LO and busy status returned to the pipeline.
interface muldiv_if;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic        start;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output in1, in2, op, start, flush,
        input  hi, lo, busy
    );

    modport slave (
        input  in1, in2, op, start, flush,
        output hi, lo, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Operands are latched as magnitudes at start; signs are reapplied in FIX.
module muldiv_unit (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    // Magnitude of a two's complement value (0x80000000 maps to itself).
    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    // acc: multiply = {partial product, multiplier}; divide = {remainder, quotient}
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] raw_a_q, raw_a_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        divz_q, divz_d;

    logic signed [31:0] a_s, b_s;
    logic [32:0] sum33;
    logic [32:0] shl33;
    logic [31:0] rem_sub;
    logic        rem_ge;
    logic [63:0] prod;
    logic        signed_op;

    assign a_s = bus.in1;
    assign b_s = bus.in2;

    // Next-state, iteration step and HI/LO write selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        raw_a_d   = raw_a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        sum33     = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
        shl33     = {acc_q[63:32], acc_q[31]};
        rem_ge    = (shl33 >= {1'b0, opb_q});
        rem_sub   = 32'(shl33 - {1'b0, opb_q});
        prod      = neg64(acc_q, neg_res_q);

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_d     = {32'd0, signed_op ? abs32(a_s) : bus.in1};
                            opb_d     = signed_op ? abs32(b_s) : bus.in2;
                            raw_a_d   = bus.in1;
                            is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                            neg_res_d = signed_op && (a_s[31] ^ b_s[31]);
                            neg_rem_d = signed_op && a_s[31];
                            divz_d    = (bus.in2 == 32'd0);
                            cnt_d     = 6'd0;
                            state_d   = CALC;
                        end
                        OP_MTHI: hi_d = bus.in1;
                        OP_MTLO: lo_d = bus.in1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                                       : {shl33[31:0], acc_q[30:0], 1'b0};
                    end else begin
                        acc_d = acc_q[0] ? {sum33, acc_q[31:1]} : {1'b0, acc_q[63:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q && divz_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = raw_a_q;
                end else if (is_div_q) begin
                    lo_d = neg32(acc_q[31:0], neg_res_q);
                    hi_d = neg32(acc_q[63:32], neg_rem_q);
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Control state and architectural HI/LO, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Datapath working registers; only meaningful while an operation runs.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        opb_q     <= opb_d;
        raw_a_q   <= raw_a_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        divz_q    <= divz_d;
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
endmodule
